// File: rtl/tile_clock_gater_pkg.sv
// Shared types and constants for the tile clock gater: channel states, register offsets, TileLink opcodes.
// No logic here beyond a byte-lane merge helper used by the register file.
package tile_clock_gater_pkg;

    typedef enum logic [1:0] {
        CH_RUN   = 2'd0,
        CH_DRAIN = 2'd1,
        CH_GATED = 2'd2,
        CH_WAKE  = 2'd3
    } ch_state_t;

    localparam logic [11:0] REG_EN     = 12'h000;
    localparam logic [11:0] REG_STATUS = 12'h008;
    localparam logic [11:0] REG_SETTLE = 12'h010;
    localparam logic [11:0] REG_WAKE   = 12'h018;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam logic [7:0] SETTLE_RST = 8'h10;
    localparam logic [7:0] WAKE_RST   = 8'h04;

    function automatic logic [63:0] lane_merge(input logic [63:0] old_val,
                                               input logic [63:0] wr_val,
                                               input logic [7:0]  mask);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[b*8 +: 8] = mask[b] ? wr_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tile_clock_gate_ch.sv
// One tile's gate sequencer (RUN/DRAIN/GATED/WAKE) with settle/wake counter; outputs registered.
// Latency: reacts to en/idle at the next clock edge; no handshake, never stalls.
module tile_clock_gate_ch
    import tile_clock_gater_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             idle,
    input  logic [CNT_W-1:0] settle,
    input  logic [CNT_W-1:0] wake,
    output logic             clk_en,
    output logic             tile_reset,
    output logic             gated
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             tile_reset_q, tile_reset_d;
    logic             gated_q, gated_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CH_RUN: begin
                if (!en) begin
                    state_d = CH_DRAIN;
                    cnt_d   = settle;
                end
            end
            CH_DRAIN: begin
                if (en) begin
                    state_d = CH_RUN;
                end else if (!idle) begin
                    cnt_d = settle;
                end else if (cnt_q == '0) begin
                    state_d = CH_GATED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CH_GATED: begin
                if (en) begin
                    state_d = CH_WAKE;
                    cnt_d   = wake;
                end
            end
            CH_WAKE: begin
                // en is deliberately not looked at until the wake count completes
                if (cnt_q == '0) begin
                    state_d = CH_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
        clk_en_d     = (state_d != CH_GATED);
        tile_reset_d = (state_d == CH_GATED) || (state_d == CH_WAKE);
        gated_d      = (state_d == CH_GATED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CH_RUN;
            cnt_q        <= '0;
            clk_en_q     <= 1'b1;
            tile_reset_q <= 1'b0;
            gated_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_en_q     <= clk_en_d;
            tile_reset_q <= tile_reset_d;
            gated_q      <= gated_d;
        end
    end

    assign clk_en     = clk_en_q;
    assign tile_reset = tile_reset_q;
    assign gated      = gated_q;

endmodule

// File: rtl/tile_clock_gater_nch.sv
// TileLink-UL register block driving N_CH tile clock-gate sequencers; response registered one cycle after accept.
// One-entry response buffer: a_ready = ~d_valid | d_ready, so accept and drain may share a cycle.
module tile_clock_gater_nch
    import tile_clock_gater_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SRC_W = 11,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [1:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [11:0]      a_address,
    input  logic [7:0]       a_mask,
    input  logic [63:0]      a_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic [63:0]      d_data,
    input  logic [N_CH-1:0]  idle,
    output logic [N_CH-1:0]  clk_en,
    output logic [N_CH-1:0]  tile_reset
);

    logic [N_CH-1:0]  en_q, en_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] wake_q, wake_d;
    logic             d_valid_q, d_valid_d;
    logic [2:0]       d_opcode_q, d_opcode_d;
    logic [1:0]       d_size_q, d_size_d;
    logic [SRC_W-1:0] d_source_q, d_source_d;
    logic [63:0]      d_data_q, d_data_d;
    logic [N_CH-1:0]  gated;

    logic        acc, is_put, is_get;
    logic [11:0] reg_sel;
    logic [63:0] rd_data, merged_en, merged_settle, merged_wake;
    logic        unused_bits;

    assign a_ready = ~d_valid_q | d_ready;
    assign acc     = a_valid & a_ready;
    assign is_put  = (a_opcode == TL_PUT_FULL) || (a_opcode == TL_PUT_PARTIAL);
    assign is_get  = (a_opcode == TL_GET);
    assign reg_sel = {a_address[11:3], 3'b000};

    assign merged_en     = lane_merge(64'(en_q), a_data, a_mask);
    assign merged_settle = lane_merge(64'(settle_q), a_data, a_mask);
    assign merged_wake   = lane_merge(64'(wake_q), a_data, a_mask);
    assign unused_bits   = ^{a_address[2:0], merged_en[63:N_CH],
                             merged_settle[63:CNT_W], merged_wake[63:CNT_W]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_EN:     rd_data = 64'(en_q);
            REG_STATUS: rd_data = 64'(gated);
            REG_SETTLE: rd_data = 64'(settle_q);
            REG_WAKE:   rd_data = 64'(wake_q);
            default:    rd_data = '0;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        settle_d   = settle_q;
        wake_d     = wake_q;
        d_valid_d  = d_valid_q & ~d_ready;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        if (acc) begin
            d_valid_d  = 1'b1;
            d_opcode_d = is_put ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
            d_size_d   = a_size;
            d_source_d = a_source;
            d_data_d   = is_get ? rd_data : '0;
            if (is_put) begin
                case (reg_sel)
                    REG_EN:     en_d     = merged_en[N_CH-1:0];
                    REG_SETTLE: settle_d = merged_settle[CNT_W-1:0];
                    REG_WAKE:   wake_d   = merged_wake[CNT_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= '1;
            settle_q   <= CNT_W'(SETTLE_RST);
            wake_q     <= CNT_W'(WAKE_RST);
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
        end else begin
            en_q       <= en_d;
            settle_q   <= settle_d;
            wake_q     <= wake_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
        end
    end

    assign d_valid  = d_valid_q;
    assign d_opcode = d_opcode_q;
    assign d_size   = d_size_q;
    assign d_source = d_source_q;
    assign d_data   = d_data_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tile_clock_gate_ch #(.CNT_W(CNT_W)) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .en         (en_q[i]),
            .idle       (idle[i]),
            .settle     (settle_q),
            .wake       (wake_q),
            .clk_en     (clk_en[i]),
            .tile_reset (tile_reset[i]),
            .gated      (gated[i])
        );
    end

endmodule

// File: tb/tb_tile_clock_gater_nch.sv
// Directed bench for tile_clock_gater_nch: expected responses queued at acceptance, checked by a monitor.
module tb_tile_clock_gater_nch;

    localparam int N_CH  = 4;
    localparam int SRC_W = 11;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             a_valid, a_ready;
    logic [2:0]       a_opcode;
    logic [1:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [11:0]      a_address;
    logic [7:0]       a_mask;
    logic [63:0]      a_data;
    logic             d_valid, d_ready;
    logic [2:0]       d_opcode;
    logic [1:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic [63:0]      d_data;
    logic [N_CH-1:0]  idle, clk_en, tile_reset;

    tile_clock_gater_nch #(.N_CH(N_CH), .SRC_W(SRC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_data(d_data),
        .idle(idle), .clk_en(clk_en), .tile_reset(tile_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       op;
        logic [1:0]       size;
        logic [SRC_W-1:0] src;
        logic [63:0]      data;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               tests = 0;
    int               fails = 0;
    int               edges = 0;
    int               acc_edge = 0;
    int               a0, t, n, prev;
    logic [SRC_W-1:0] src_ctr = '0;

    always @(posedge clock) edges <= edges + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (edge %0d)", name, act, req, edges);
        end
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Issue one request; expected response pushed at the accepting edge.
    task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] data,
                        input logic [7:0] mask, input logic [63:0] exp_data);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = src_ctr[1:0];
        a_source  = src_ctr;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("a_ready_wait", 64'(ok), 64'd1);
        @(posedge clock);
        if (ok) begin
            e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
            e.size = src_ctr[1:0];
            e.src  = src_ctr;
            e.data = exp_data;
            exp_q.push_back(e);
        end
        #1;
        acc_edge = edges;
        if (ok) chk("resp_latency", 64'(d_valid), 64'd1);
        src_ctr++;
        a_valid = 1'b0;
    endtask

    task automatic wait_fall(input int ch, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!clk_en[ch]) begin
                at = edges;
                break;
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && d_valid && d_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: actual d_data 0x%0h required no response", d_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("d_opcode", 64'(d_opcode), 64'(mon_e.op));
                chk("d_size", 64'(d_size), 64'(mon_e.size));
                chk("d_source", 64'(d_source), 64'(mon_e.src));
                chk("d_data", d_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1; idle = '1;
        repeat (2) sync();
        chk("rst_clk_en", 64'(clk_en), 64'hF);
        chk("rst_tile_reset", 64'(tile_reset), 64'h0);
        chk("rst_d_valid", 64'(d_valid), 64'h0);
        chk("rst_d_data", d_data, 64'h0);
        reset_n = 1'b1;
        sync();

        // Reset values readable
        send(3'd4, 12'h000, 64'h0, 8'h00, 64'hF);
        send(3'd4, 12'h008, 64'h0, 8'h00, 64'h0);
        chk("clk_en_after_rst", 64'(clk_en), 64'hF);

        // Gate channel 0: 1 EN-write cycle + 17 drain cycles
        send(3'd0, 12'h000, 64'hE, 8'h01, 64'h0);
        a0 = acc_edge;
        wait_fall(0, t);
        chk("gate_delay", 64'(t - a0), 64'd18);
        chk("gated_clk_en", 64'(clk_en), 64'hE);
        chk("gated_tile_reset", 64'(tile_reset), 64'h1);
        sync();
        send(3'd4, 12'h008, 64'h0, 8'h00, 64'h1);

        // Wake with WAKE=4: clk_en back next cycle, tile_reset held 5 cycles
        send(3'd0, 12'h000, 64'hF, 8'h01, 64'h0);
        @(negedge clock);
        chk("wake_pre_clk_en", 64'(clk_en[0]), 64'd0);
        @(negedge clock);
        chk("wake_clk_en", 64'(clk_en[0]), 64'd1);
        n = 0;
        for (int i = 0; i < 20 && tile_reset[0]; i++) begin
            n++;
            @(negedge clock);
        end
        chk("wake_reset_hold", 64'(n), 64'd5);
        chk("wake_done_tile_reset", 64'(tile_reset), 64'h0);
        sync();
        send(3'd4, 12'h008, 64'h0, 8'h00, 64'h0);

        // idle[0] low at drain cycle 10 reloads the counter: 18 + 10 cycles total
        send(3'd0, 12'h000, 64'hE, 8'h01, 64'h0);
        a0 = acc_edge;
        repeat (10) @(posedge clock);
        #1 idle = 4'hE;
        @(posedge clock);
        #1 idle = 4'hF;
        wait_fall(0, t);
        chk("idle_pulse_delay", 64'(t - a0), 64'd28);
        sync();
        send(3'd0, 12'h000, 64'hF, 8'h01, 64'h0);
        repeat (8) sync();
        chk("rewake_clk_en", 64'(clk_en), 64'hF);
        chk("rewake_tile_reset", 64'(tile_reset), 64'h0);

        // Register map, byte masks, unmapped and read-only addresses
        send(3'd0, 12'h010, 64'h05, 8'h01, 64'h0);
        send(3'd4, 12'h010, 64'h0, 8'h00, 64'h05);
        send(3'd1, 12'h010, 64'hAA, 8'h00, 64'h0);
        send(3'd4, 12'h010, 64'h0, 8'h00, 64'h05);
        send(3'd0, 12'h018, 64'h1234, 8'hFF, 64'h0);
        send(3'd4, 12'h018, 64'h0, 8'h00, 64'h34);
        send(3'd0, 12'h000, 64'h0, 8'h02, 64'h0);
        send(3'd4, 12'h004, 64'h0, 8'h00, 64'hF);
        send(3'd0, 12'h020, 64'hFFFF, 8'hFF, 64'h0);
        send(3'd4, 12'h020, 64'h0, 8'h00, 64'h0);
        send(3'd0, 12'h008, 64'hFF, 8'hFF, 64'h0);
        send(3'd4, 12'h008, 64'h0, 8'h00, 64'h0);

        // SETTLE=0 gates one cycle after DRAIN entry; WAKE=0 runs one cycle after WAKE entry
        send(3'd0, 12'h010, 64'h0, 8'h01, 64'h0);
        send(3'd0, 12'h018, 64'h0, 8'h01, 64'h0);
        send(3'd0, 12'h000, 64'hD, 8'h01, 64'h0);
        a0 = acc_edge;
        wait_fall(1, t);
        chk("settle0_delay", 64'(t - a0), 64'd2);
        sync();
        send(3'd0, 12'h000, 64'hF, 8'h01, 64'h0);
        @(negedge clock);
        chk("wake0_pre", 64'(clk_en[1]), 64'd0);
        @(negedge clock);
        chk("wake0_clk_en", 64'(clk_en[1]), 64'd1);
        chk("wake0_reset", 64'(tile_reset[1]), 64'd1);
        @(negedge clock);
        chk("wake0_run", 64'(tile_reset[1]), 64'd0);
        sync();
        send(3'd0, 12'h010, 64'h10, 8'h01, 64'h0);
        send(3'd0, 12'h018, 64'h04, 8'h01, 64'h0);

        // Backpressure: held response stays stable, second request stalls
        sync();
        d_ready = 1'b0;
        send(3'd4, 12'h010, 64'h0, 8'h00, 64'h10);
        fork
            send(3'd4, 12'h018, 64'h0, 8'h00, 64'h04);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("bp_a_ready", 64'(a_ready), 64'd0);
                    chk("bp_d_valid", 64'(d_valid), 64'd1);
                    chk("bp_d_data", d_data, 64'h10);
                    chk("bp_d_opcode", 64'(d_opcode), 64'd1);
                end
                @(posedge clock);
                #1 d_ready = 1'b1;
            end
        join
        for (int i = 0; i < 4; i++) begin
            send(3'd4, 12'h000, 64'h0, 8'h00, 64'hF);
            if (i > 0) chk("throughput_gap", 64'(acc_edge - prev), 64'd1);
            prev = acc_edge;
        end

        // Reset during DRAIN aborts sequencing and drops the pending response
        sync();
        send(3'd0, 12'h000, 64'h0, 8'h01, 64'h0);
        repeat (5) sync();
        chk("pre_rst_drain_clk_en", 64'(clk_en), 64'hF);
        d_ready = 1'b0;
        send(3'd4, 12'h008, 64'h0, 8'h00, 64'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_clk_en", 64'(clk_en), 64'hF);
        chk("mid_rst_tile_reset", 64'(tile_reset), 64'h0);
        chk("mid_rst_d_valid", 64'(d_valid), 64'd0);
        chk("mid_rst_d_data", d_data, 64'h0);
        exp_q.delete();
        sync();
        reset_n = 1'b1;
        d_ready = 1'b1;
        send(3'd4, 12'h000, 64'h0, 8'h00, 64'hF);
        repeat (25) sync();
        chk("post_rst_clk_en", 64'(clk_en), 64'hF);

        repeat (3) sync();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
